// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell reused LSB-first over WIDTH cycles.
// Results only update on completion, so sum/cout/overflow never show partial values.

module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);
endmodule

module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-2:0] sh_q;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             bit_s, bit_c;

    fa_cell u_fa (
        .x  (a_q[cnt]),
        .y  (b_q[cnt]),
        .ci (carry_q),
        .s  (bit_s),
        .co (bit_c)
    );

    // New bit enters at the top; after WIDTH shifts bit 0 has reached the LSB.
    assign shifted = {bit_s, sh_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADD;
            ADD:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            cnt      <= '0;
            carry_q  <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                // Subtraction as a + ~b + 1: invert b and seed the carry.
                a_q     <= a;
                b_q     <= b ^ {WIDTH{sub}};
                carry_q <= sub;
                cnt     <= '0;
            end else if (state == ADD) begin
                sh_q    <= shifted[WIDTH-1:1];
                carry_q <= bit_c;
                cnt     <= cnt + CW'(1);
                if (cnt == LAST) begin
                    sum      <= shifted;
                    cout     <= bit_c;
                    overflow <= carry_q ^ bit_c;
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-006 a  input  WIDTH  operand A; sampled with start.
REQ-007 b  input  WIDTH  operand B; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress (ADD or DONE state).
REQ-009 done  output  1  one-cycle pulse marking valid new results.
REQ-010 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-011 cout  output  1  carry out of MSB; for subtract, 1 = no borrow (a >= b unsigned).
REQ-012 overflow  output  1  two's-complement signed overflow.

Function
REQ-013 Datapath SHALL be a single one-bit full-adder cell (sum = x^y^c, carry = majority) reused over WIDTH cycles, LSB first, with a registered carry.
REQ-014 FSM SHALL have states IDLE, ADD, DONE.
REQ-015 IDLE: on rising edge with start=1, capture a, (b XOR {WIDTH{sub}}), and carry = sub; clear bit counter; go to ADD.
REQ-016 IDLE with start=0 SHALL remain in IDLE with no register change.
REQ-017 ADD: each edge SHALL compute bit[count], shift it into the result shift register MSB-first-fill, update carry, increment count.
REQ-018 ADD SHALL last exactly WIDTH cycles; the edge that processes bit WIDTH-1 SHALL move to DONE.
REQ-019 On that same edge sum, cout, and overflow (carry into MSB XOR carry out of MSB) SHALL be loaded; done SHALL be high for the whole single DONE cycle.
REQ-020 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-021 Latency: start sampled at edge k -> done high in the cycle following edge k+WIDTH; throughput one operation per WIDTH+2 cycles.
REQ-022 start, sub, a, b SHALL be ignored in ADD and DONE; operands changing mid-operation SHALL NOT affect the result.
REQ-023 sum, cout, overflow SHALL hold their last completed values until the next done; they SHALL NOT show partial results.
REQ-024 busy SHALL be low only in IDLE; start asserted in the DONE cycle SHALL be ignored (no back-to-back acceptance).
REQ-025 Bit counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-026 rst=1 SHALL immediately, without a clock edge, force IDLE, and clear count, carry, operand and shift registers, sum, cout, overflow, busy, done to 0.
REQ-027 rst asserted mid-operation SHALL abort it; no done pulse SHALL be produced for the aborted operation.
REQ-028 After rst deasserts, the first start SHALL be accepted on the first rising edge at which start=1.

Verification (WIDTH=8)
REQ-029 a=0x0F, b=0x01, sub=0, start at edge k -> done in cycle after edge k+8, sum=0x10, cout=0, overflow=0.
REQ-030 a=0xFF, b=0x01, sub=0 -> sum=0x00, cout=1, overflow=0; a=0x7F, b=0x01 -> sum=0x80, cout=0, overflow=1.
REQ-031 a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, overflow=0; a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, overflow=1.
REQ-032 start held high continuously with operands changed every cycle -> exactly one done per 10 cycles, each result matches operands captured at the accepting edge.
REQ-033 rst pulsed at ADD cycle 4 between clock edges -> all outputs 0 immediately, no done, next operation 0x03+0x04 -> sum=0x07.
REQ-034 Exhaustive random: 1000 operations for WIDTH=2, 8, 64 compared against reference model {cout,sum} = a + (sub ? ~b+1 : b) and signed overflow rule.
